// File: rtl/adbg_pkg.sv
// Shared constants for the advanced debug interface: data register length and
// the layout of the top-level status word.
package adbg_pkg;
  localparam int ADBG_DATA_LEN     = 53;
  localparam int ADBG_TOP_STATUS_W = 16;
  localparam int ADBG_ST_VALID     = 0;
  localparam int ADBG_ST_ERR       = 1;
  localparam int ADBG_ST_ID_LSB    = 2;
  localparam int ADBG_ST_ID_W      = 6;
  localparam int ADBG_ST_NB_LSB    = 8;

  typedef logic [ADBG_TOP_STATUS_W-1:0] adbg_status_t;

  function automatic adbg_status_t adbg_status_word(input logic valid, input logic err,
                                                    input logic [ADBG_ST_ID_W-1:0] id,
                                                    input logic [7:0] nb);
    adbg_status_t w;
    w = '0;
    w[ADBG_ST_VALID] = valid;
    w[ADBG_ST_ERR] = err;
    w[ADBG_ST_ID_LSB +: ADBG_ST_ID_W] = id;
    w[ADBG_ST_NB_LSB +: 8] = nb;
    return w;
  endfunction
endpackage

// File: rtl/adbg_top_status_sr.sv
// Capture/shift status register; bit 0 drives TDO. Capture wins over shift.
module adbg_top_status_sr
  import adbg_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture,
  input  logic                         shift,
  input  logic [ADBG_TOP_STATUS_W-1:0] load_val,
  output logic                         tdo
);
  logic [ADBG_TOP_STATUS_W-1:0] st;

  always_ff @(posedge clk) begin
    if (!rst_n)       st <= '0;
    else if (capture) st <= load_val;
    else if (shift)   st <= {1'b0, st[ADBG_TOP_STATUS_W-1:1]};
  end

  assign tdo = st[0];
endmodule

// File: rtl/adbg_top_sel.sv
// Top-level debug module selector: one-hot select, inhibit, TDO mux, range check.
// Optional status chain on TDO when no module is selected: ADBG_TOP_STATUS_EN.
module adbg_top_sel
  import adbg_pkg::*;
#(
  parameter int NB_MODULES  = 4,
  parameter int MODULE_ID_W = 5,
  parameter int DATA_LEN    = ADBG_DATA_LEN
) (
  input  logic                  tck_i,
  input  logic                  trstn_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  input  logic                  shift_dr_i,
  input  logic                  capture_dr_i,
  input  logic                  update_dr_i,
  input  logic                  pause_dr_i,
  input  logic                  debug_select_i,
  output logic [DATA_LEN-1:0]   data_register_o,
  output logic [NB_MODULES-1:0] module_select_o,
  input  logic [NB_MODULES-1:0] module_tdo_i,
  input  logic [NB_MODULES-1:0] module_inhibit_i,
  output logic                  select_valid_o,
  output logic                  select_err_o
);
  logic [DATA_LEN-1:0]    sr;
  logic [MODULE_ID_W-1:0] id, id_in;
  logic                   valid, select_err;
  logic                   select_cmd, inhibit, in_range, load_id;
  logic                   tdo_mod, tdo_idle;

  assign select_cmd = sr[DATA_LEN-1];
  assign id_in      = sr[DATA_LEN-2 -: MODULE_ID_W];
  assign inhibit    = |module_inhibit_i;
  // No wrap-around: an ID equal to NB_MODULES is out of range.
  assign in_range   = 32'(id_in) < 32'(NB_MODULES);
  assign load_id    = debug_select_i && update_dr_i && select_cmd && !inhibit;

  always_ff @(posedge tck_i) begin
    if (!trstn_i) begin
      sr         <= '0;
      id         <= '0;
      valid      <= 1'b1;
      select_err <= 1'b0;
    end else begin
      if (debug_select_i && shift_dr_i) sr <= {tdi_i, sr[DATA_LEN-1:1]};
      if (load_id) begin
        id         <= id_in;
        valid      <= in_range;
        select_err <= !in_range;
      end
    end
  end

  for (genvar i = 0; i < NB_MODULES; i++) begin : g_sel
    assign module_select_o[i] = valid && (id == MODULE_ID_W'(i));
  end

  always_comb begin
    tdo_mod = 1'b0;
    for (int i = 0; i < NB_MODULES; i++)
      if (id == MODULE_ID_W'(i)) tdo_mod = module_tdo_i[i];
  end

  // Pause only freezes the chain, which is already the hold behaviour.
  logic unused;
`ifdef ADBG_TOP_STATUS_EN
  assign unused = pause_dr_i;

  adbg_top_status_sr u_status (
    .clk      (tck_i),
    .rst_n    (trstn_i),
    .capture  (debug_select_i && capture_dr_i && !valid),
    .shift    (debug_select_i && shift_dr_i && !valid),
    .load_val (adbg_status_word(valid, select_err, ADBG_ST_ID_W'(id), 8'(NB_MODULES))),
    .tdo      (tdo_idle)
  );
`else
  assign unused   = ^{pause_dr_i, capture_dr_i};
  assign tdo_idle = 1'b0;
`endif

  assign tdo_o           = valid ? tdo_mod : tdo_idle;
  assign data_register_o = sr;
  assign select_valid_o  = valid;
  assign select_err_o    = select_err;
endmodule
